// File: rtl/jk_excitation_driver_if.sv
// Handshake and excitation bundle between a JK excitation driver and its user.
// The slave side is the driver; the master side issues loads and watches J/K and the Q model.
interface jk_excitation_driver_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic             load;
    logic [WIDTH-1:0] pattern;
    logic             ready;
    logic             busy;
    logic             J;
    logic             K;
    logic             q_model;
    logic [IDX_W-1:0] bit_idx;
    logic             done;
    logic             mismatch;

    modport master (
        output load, pattern,
        input  ready, busy, J, K, q_model, bit_idx, done, mismatch
    );

    modport slave (
        input  load, pattern,
        output ready, busy, J, K, q_model, bit_idx, done, mismatch
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives J/K so that a downstream JK flip-flop on the same clock replays a pattern LSB first.
// Optional macro JK_TOGGLE_EN: encode required Q changes as toggle (J=K=1) instead of set/reset.
module jk_excitation_driver #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input logic                   clk,
    input logic                   rst_n,
    jk_excitation_driver_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] pattern_reg;
    logic [IDX_W-1:0] bit_idx_reg;
    logic             q_model_reg;

    logic target_bit;
    logic j_dec;
    logic k_dec;

    assign target_bit = pattern_reg[bit_idx_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            pattern_reg <= '0;
            bit_idx_reg <= '0;
            q_model_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.load) begin
                        pattern_reg <= bus.pattern;
                        state_reg   <= S_INIT;
                    end
                end
                S_INIT: begin
                    // K=1 this cycle clears the downstream Q whatever it held before.
                    q_model_reg <= 1'b0;
                    bit_idx_reg <= '0;
                    state_reg   <= S_SHIFT;
                end
                S_SHIFT: begin
                    q_model_reg <= target_bit;
                    if (bit_idx_reg == LAST_IDX) begin
                        state_reg <= S_DONE;
                    end else begin
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Excitation depends only on registered state, so J/K settle a full cycle before the edge.
    always_comb begin
        j_dec = 1'b0;
        k_dec = 1'b0;
        case (state_reg)
            S_INIT: begin
                k_dec = 1'b1;
            end
            S_SHIFT: begin
                if (target_bit != q_model_reg) begin
`ifdef JK_TOGGLE_EN
                    j_dec = 1'b1;
                    k_dec = 1'b1;
`else
                    j_dec = target_bit;
                    k_dec = ~target_bit;
`endif
                end
            end
            default: begin
                j_dec = 1'b0;
                k_dec = 1'b0;
            end
        endcase
    end

    assign bus.J        = j_dec;
    assign bus.K        = k_dec;
    assign bus.ready    = (state_reg == S_IDLE);
    assign bus.busy     = (state_reg == S_INIT) || (state_reg == S_SHIFT);
    assign bus.done     = (state_reg == S_DONE);
    assign bus.q_model  = q_model_reg;
    assign bus.bit_idx  = bit_idx_reg;
    // Downstream Q is compared against q_model outside this block.
    assign bus.mismatch = 1'b0;
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver: 8-bit and 2-bit instances each feed a JK flip-flop model.
module tb_jk_excitation_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jk_excitation_driver_if #(.WIDTH(8)) bus8 ();
    jk_excitation_driver_if #(.WIDTH(2)) bus2 ();

    jk_excitation_driver #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    jk_excitation_driver #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

`ifdef JK_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    // {J,K} per SHIFT cycle, cycle 0 in the two MSBs.
    localparam logic [15:0] TAB_B2   = TOG ? 16'b00_11_11_00_11_00_11_11 : 16'b00_10_01_00_10_00_01_10;
    localparam logic [15:0] TAB_FF   = TOG ? 16'b11_00_00_00_00_00_00_00 : 16'b10_00_00_00_00_00_00_00;
    localparam logic [15:0] TAB_80   = TOG ? 16'b00_00_00_00_00_00_00_11 : 16'b00_00_00_00_00_00_00_10;
    localparam logic [15:0] TAB_00   = 16'h0000;
    localparam logic [1:0]  CHG_HIGH = TOG ? 2'b11 : 2'b10;

    // Downstream JK flip-flops, no reset, as a real device would be.
    logic q_ff  = 1'b0;
    logic q_ff2 = 1'b0;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    always @(posedge clk) begin
        q_ff  <= jk_next(q_ff, bus8.J, bus8.K);
        q_ff2 <= jk_next(q_ff2, bus2.J, bus2.K);
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus8.ready, bus8.busy, bus8.J, bus8.K, bus8.q_model, bus8.bit_idx, bus8.done, bus8.mismatch} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_initial: rdy/busy/J/K/q/idx/done/mm got %b %b %b %b %b %0d %b %b", bus8.ready, bus8.busy, bus8.J, bus8.K, bus8.q_model, bus8.bit_idx, bus8.done, bus8.mismatch);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        // start a run and abort it at bit_idx 3
        bus8.pattern = 8'hB2;
        bus8.load    = 1'b1;
        step();
        bus8.load = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if ({bus8.busy, bus8.bit_idx} !== {1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL reset_pre_abort: busy/idx got %b %0d want 1 3", bus8.busy, bus8.bit_idx);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus8.ready, bus8.busy, bus8.J, bus8.K, bus8.q_model, bus8.bit_idx, bus8.done} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_abort: rdy/busy/J/K/q/idx/done got %b %b %b %b %b %0d %b want 1 0 0 0 0 0 0", bus8.ready, bus8.busy, bus8.J, bus8.K, bus8.q_model, bus8.bit_idx, bus8.done);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({bus8.done, bus8.ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL reset_hold: done/ready got %b %b want 0 1", bus8.done, bus8.ready);
            end
        end
        rst_n = 1'b1;
        step();
        $display("test_reset: mid-SHIFT abort checked");
    endtask

    task automatic run8(input logic [7:0] pat, input logic [15:0] jk_exp, input string name);
        logic exp_q;
        bus8.pattern = pat;
        bus8.load    = 1'b1;
        step();
        bus8.load = 1'b0;
        n_cmp++;
        if ({bus8.busy, bus8.ready, bus8.J, bus8.K} !== 4'b1001) begin
            n_fail++;
            $display("FAIL %s_init: busy/ready/J/K got %b%b%b%b want 1001", name, bus8.busy, bus8.ready, bus8.J, bus8.K);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            exp_q = 1'b0;
            if (i > 0) exp_q = pat[i-1];
            n_cmp++;
            if ({bus8.J, bus8.K} !== jk_exp[15-2*i -: 2] || bus8.bit_idx !== 3'(i)) begin
                n_fail++;
                $display("FAIL %s_jk[%0d]: JK=%b%b idx=%0d want JK=%b idx=%0d", name, i, bus8.J, bus8.K, bus8.bit_idx, jk_exp[15-2*i -: 2], i);
            end
            n_cmp++;
            if (bus8.q_model !== exp_q || q_ff !== exp_q) begin
                n_fail++;
                $display("FAIL %s_q[%0d]: q_model=%b q_ff=%b want %b", name, i, bus8.q_model, q_ff, exp_q);
            end
        end
        step();
        n_cmp++;
        if ({bus8.done, bus8.busy, bus8.J, bus8.K, bus8.q_model, q_ff, bus8.bit_idx, bus8.mismatch} !== {1'b1, 1'b0, 1'b0, 1'b0, pat[7], pat[7], 3'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_done: done/busy/J/K/q/qff/idx/mm got %b %b %b %b %b %b %0d %b want 1 0 0 0 %b %b 7 0", name, bus8.done, bus8.busy, bus8.J, bus8.K, bus8.q_model, q_ff, bus8.bit_idx, bus8.mismatch, pat[7], pat[7]);
        end
        step();
        n_cmp++;
        if ({bus8.done, bus8.ready, bus8.bit_idx} !== {1'b0, 1'b1, 3'd7}) begin
            n_fail++;
            $display("FAIL %s_idle: done/ready/idx got %b %b %0d want 0 1 7", name, bus8.done, bus8.ready, bus8.bit_idx);
        end
        $display("run8 %s: pattern=%h q_end=%b", name, pat, q_ff);
    endtask

    task automatic test_pattern_b2();
        run8(8'hB2, TAB_B2, "b2");
    endtask

    task automatic test_back_to_back();
        bus8.pattern = 8'hFF;
        bus8.load    = 1'b1;
        step();
        bus8.pattern = 8'h00;   // load stays high through the whole first run
        n_cmp++;
        if ({bus8.J, bus8.K} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_init1: JK=%b%b want 01", bus8.J, bus8.K);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if ({bus8.J, bus8.K} !== TAB_FF[15-2*i -: 2] || bus8.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_run1[%0d]: JK=%b%b busy=%b want JK=%b busy=1", i, bus8.J, bus8.K, bus8.busy, TAB_FF[15-2*i -: 2]);
            end
        end
        step();
        n_cmp++;
        if ({bus8.done, bus8.q_model, q_ff} !== 3'b111) begin
            n_fail++;
            $display("FAIL b2b_done1: done/q/qff got %b %b %b want 1 1 1", bus8.done, bus8.q_model, q_ff);
        end
        step();
        n_cmp++;
        if ({bus8.ready, bus8.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_idle: ready/busy got %b %b want 1 0", bus8.ready, bus8.busy);
        end
        step();
        bus8.load = 1'b0;
        n_cmp++;
        if ({bus8.busy, bus8.J, bus8.K} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_init2: busy/J/K got %b %b %b want 1 0 1", bus8.busy, bus8.J, bus8.K);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if ({bus8.J, bus8.K, bus8.q_model, q_ff} !== 4'b0000) begin
                n_fail++;
                $display("FAIL b2b_run2[%0d]: J/K/q/qff got %b %b %b %b want 0 0 0 0", i, bus8.J, bus8.K, bus8.q_model, q_ff);
            end
        end
        step();
        n_cmp++;
        if ({bus8.done, bus8.q_model, q_ff} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_done2: done/q/qff got %b %b %b want 1 0 0", bus8.done, bus8.q_model, q_ff);
        end
        step();
        $display("test_back_to_back: FF then 00, q_end=%b", q_ff);
    endtask

    task automatic test_init();
        run8(8'h80, TAB_80, "pre80");
        n_cmp++;
        if (q_ff !== 1'b1) begin
            n_fail++;
            $display("FAIL init_preload: q_ff got %b want 1", q_ff);
        end
        run8(8'h00, TAB_00, "init00");
    endtask

    task automatic test_width2();
        bus2.pattern = 2'b10;
        bus2.load    = 1'b1;
        step();
        bus2.load = 1'b0;
        n_cmp++;
        if ({bus2.busy, bus2.J, bus2.K} !== 3'b101) begin
            n_fail++;
            $display("FAIL w2_init: busy/J/K got %b %b %b want 1 0 1", bus2.busy, bus2.J, bus2.K);
        end
        step();
        n_cmp++;
        if ({bus2.J, bus2.K, bus2.bit_idx, q_ff2} !== {2'b00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL w2_shift0: JK=%b%b idx=%0d qff=%b want 00 0 0", bus2.J, bus2.K, bus2.bit_idx, q_ff2);
        end
        step();
        n_cmp++;
        if ({bus2.J, bus2.K, bus2.bit_idx, bus2.q_model} !== {CHG_HIGH, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL w2_shift1: JK=%b%b idx=%0d q=%b want %b 1 0", bus2.J, bus2.K, bus2.bit_idx, bus2.q_model, CHG_HIGH);
        end
        step();
        n_cmp++;
        if ({bus2.done, bus2.bit_idx, bus2.q_model, q_ff2} !== 4'b1111) begin
            n_fail++;
            $display("FAIL w2_done: done/idx/q/qff got %b %0d %b %b want 1 1 1 1", bus2.done, bus2.bit_idx, bus2.q_model, q_ff2);
        end
        step();
        n_cmp++;
        if ({bus2.done, bus2.ready, bus2.bit_idx} !== 3'b011) begin
            n_fail++;
            $display("FAIL w2_idle: done/ready/idx got %b %b %0d want 0 1 1", bus2.done, bus2.ready, bus2.bit_idx);
        end
        $display("test_width2: pattern 10 q_end=%b", q_ff2);
    endtask

    initial begin
        bus8.load    = 1'b0;
        bus8.pattern = '0;
        bus2.load    = 1'b0;
        bus2.pattern = '0;
        #1;
        test_reset();
        test_pattern_b2();
        test_back_to_back();
        test_init();
        test_width2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
